// File: rtl/load24_seq.sv
// load24_seq: streaming sequencer for the combinational load24_littleEndian
// (CBD eta=3) function unit. Repacks a frame of little-endian 32-bit words
// into consecutive 24-bit chunks and issues one chunk per cycle to the unit.
// Each rd2 result is registered and presented on a valid/ready output stream.
//
// Build option: define ATHOS_LOAD24_PAD_EN to zero-pad the 1- or 2-byte frame
// residue into one extra chunk that carries out_last_o. Without it the residue
// is dropped and out_last_o rides the last full chunk.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   input word handshake
//   in_data_i, in_last_i    input word (byte0 = [7:0] earliest), end of frame
//   fu_valid_o, fu_rs1_o    chunk issued to the FU this cycle ({8'h00, chunk})
//   fu_rd2_i                FU combinational result
//   out_valid_o/out_ready_i output result handshake
//   out_data_o, out_last_o  registered FU result, final result of frame
//   chunk_cnt_o             chunks emitted in the current frame
//   busy_o                  sequencer is not idle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first word of a frame
// FILL  | accepting words, emitting chunks as bytes become available
// DRAIN | last word taken; emitting remaining chunks until final handshake

module load24_seq #(
    parameter int CNT_W     = 16,
    parameter int BUF_BYTES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    output logic             fu_valid_o,
    output logic [31:0]      fu_rs1_o,
    input  logic [31:0]      fu_rd2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] chunk_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUF_W  = 8 * BUF_BYTES;
    localparam int FILL_W = $clog2(BUF_BYTES + 1);

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  byte_buf_q, byte_buf_d, byte_buf_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_shift;
    logic              in_ready_d;
    logic              accept, slot_free, emit, emit_last;

    always_comb begin
        accept    = in_valid_i && in_ready_o;
        slot_free = !out_valid_o || out_ready_i;

`ifdef ATHOS_LOAD24_PAD_EN
        // A 1- or 2-byte residue in DRAIN goes out as a zero-padded chunk;
        // bytes above fill are always zero so the buffer already holds the pad.
        emit      = slot_free && ((fill_q >= FILL_W'(3)) ||
                                  (state_q == ST_DRAIN && fill_q != '0));
        emit_last = emit && (state_q == ST_DRAIN) && (fill_q <= FILL_W'(3));
`else
        emit      = slot_free && (fill_q >= FILL_W'(3));
        emit_last = emit && (state_q == ST_DRAIN) && (fill_q < FILL_W'(6));
`endif

        fu_valid_o = emit;
        fu_rs1_o   = emit ? {8'h00, byte_buf_q[23:0]} : 32'h0;

        byte_buf_shift = byte_buf_q;
        fill_shift     = fill_q;
        if (emit) begin
            byte_buf_shift = byte_buf_q >> 24;
            fill_shift     = (fill_q >= FILL_W'(3)) ? fill_q - FILL_W'(3) : '0;
        end
        // The final chunk of a frame leaves nothing behind: any residue is
        // either already padded out or discarded here.
        if (emit_last) begin
            byte_buf_shift = '0;
            fill_shift     = '0;
        end

        byte_buf_d = byte_buf_shift;
        fill_d     = fill_shift;
        if (accept) begin
            byte_buf_d = byte_buf_shift | (BUF_W'(in_data_i) << {fill_shift, 3'b000});
            fill_d     = fill_shift + FILL_W'(4);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = in_last_i ? ST_DRAIN : ST_FILL;
            ST_FILL:  if (accept && in_last_i) state_d = ST_DRAIN;
            ST_DRAIN: if (out_valid_o && out_ready_i && out_last_o) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Registered ready: in FILL it reflects the fill level at the start of
        // the cycle it is presented in, so room for a full word is guaranteed.
        in_ready_d = (state_d == ST_IDLE) ||
                     (state_d == ST_FILL && fill_d <= FILL_W'(4));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            byte_buf_q  <= '0;
            fill_q      <= '0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            chunk_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            byte_buf_q <= byte_buf_d;
            fill_q     <= fill_d;
            in_ready_o <= in_ready_d;

            if (state_q == ST_IDLE && accept) begin
                chunk_cnt_o <= '0;
            end else if (emit) begin
                chunk_cnt_o <= chunk_cnt_o + CNT_W'(1);
            end

            if (emit) begin
                out_valid_o <= 1'b1;
                out_data_o  <= fu_rd2_i;
                out_last_o  <= emit_last;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule
